// File: rtl/stack_game_ctrl_if.sv
// Signal bundle between the stacking-game sequencer and its surroundings:
// buttons and the shifter's current row come in, shifter control and
// display status go out.
interface stack_game_ctrl_if;
   logic       startBtn;
   logic       stopBtn;
   logic [7:0] curBlock;
   logic [7:0] blockLoc;
   logic       loadBlock;
   logic       shiftTick;
   logic [2:0] level;
   logic [7:0] stackRow;
   logic       gameOver;
   logic       gameWin;

   // Sequencer side
   modport master (
      input  startBtn, stopBtn, curBlock,
      output blockLoc, loadBlock, shiftTick, level, stackRow, gameOver, gameWin
   );

   // Buttons / shifter / display side
   modport slave (
      output startBtn, stopBtn, curBlock,
      input  blockLoc, loadBlock, shiftTick, level, stackRow, gameOver, gameWin
   );
endinterface

// File: rtl/stack_game_ctrl.sv
// Stacking-game sequencer: loads the block shifter, paces it with shift
// ticks, captures and trims the moving row on each stop press, speeds up
// per cleared level and reports win or loss. All outputs are registered.
module stack_game_ctrl #(
   parameter logic [23:0] START_PERIOD = 24'd5_000_000,
   parameter logic [23:0] PERIOD_STEP  = 24'd500_000,
   parameter logic [23:0] MIN_PERIOD   = 24'd1_000_000,
   parameter logic [7:0]  INIT_BLOCK   = 8'b0011_1000,
   parameter int          ROWS         = 8
) (
   input logic                clk,
   input logic                rst,
   stack_game_ctrl_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_CHECK,
      S_WIN,
      S_LOSE
   } state_e;

   localparam logic [2:0]  LAST_LEVEL = 3'(ROWS - 1);
   // Widened so MIN_PERIOD + PERIOD_STEP cannot wrap.
   localparam logic [24:0] DEC_FLOOR  = {1'b0, MIN_PERIOD} + {1'b0, PERIOD_STEP};

   state_e      state_q, state_d;
   logic        start_q, stop_q;
   logic [7:0]  block_loc_q, block_loc_d;
   logic        load_q, load_d;
   logic        tick_q, tick_d;
   logic [2:0]  level_q, level_d;
   logic [7:0]  stack_row_q, stack_row_d;
   logic [7:0]  cap_row_q, cap_row_d;
   logic [23:0] period_q, period_d;
   logic [23:0] tick_cnt_q, tick_cnt_d;

   logic        start_edge, stop_edge;
   logic [7:0]  overlap;
   logic [23:0] period_dec;

   assign start_edge = bus.startBtn & ~start_q;
   assign stop_edge  = bus.stopBtn  & ~stop_q;

   // Level 0 has nothing below it, so the whole captured row survives.
   assign overlap = (level_q == 3'd0) ? cap_row_q : (cap_row_q & stack_row_q);

   // Saturating period decrement; never drops below MIN_PERIOD.
   assign period_dec = ({1'b0, period_q} < DEC_FLOOR) ? MIN_PERIOD
                                                       : (period_q - PERIOD_STEP);

   // State and datapath registers, cleared by the asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         start_q     <= 1'b0;
         stop_q      <= 1'b0;
         block_loc_q <= 8'd0;
         load_q      <= 1'b0;
         tick_q      <= 1'b0;
         level_q     <= 3'd0;
         stack_row_q <= 8'd0;
         cap_row_q   <= 8'd0;
         period_q    <= START_PERIOD;
         tick_cnt_q  <= 24'd0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values; blocking here would chain updates within a cycle.
         state_q     <= state_d;
         start_q     <= bus.startBtn;
         stop_q      <= bus.stopBtn;
         block_loc_q <= block_loc_d;
         load_q      <= load_d;
         tick_q      <= tick_d;
         level_q     <= level_d;
         stack_row_q <= stack_row_d;
         cap_row_q   <= cap_row_d;
         period_q    <= period_d;
         tick_cnt_q  <= tick_cnt_d;
      end
   end

   // Next-state and next-output logic for the game sequence.
   always_comb begin
      // NOTE: every target gets a default first, so no path can leave a
      // variable unassigned and infer a latch.
      state_d     = state_q;
      block_loc_d = block_loc_q;
      load_d      = 1'b0;
      tick_d      = 1'b0;
      level_d     = level_q;
      stack_row_d = stack_row_q;
      cap_row_d   = cap_row_q;
      period_d    = period_q;
      tick_cnt_d  = tick_cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (start_edge) begin
               state_d     = S_LOAD;
               block_loc_d = INIT_BLOCK;
               level_d     = 3'd0;
               stack_row_d = 8'd0;
               period_d    = START_PERIOD;
               tick_cnt_d  = 24'd0;
               load_d      = 1'b1;
            end
         end

         S_LOAD: begin
            // The load cycle itself is count 0, so the first tick lands
            // exactly one period after the load pulse.
            tick_cnt_d = 24'd1;
            state_d    = S_RUN;
         end

         S_RUN: begin
            if (stop_edge) begin
               // A stop wins over a coinciding tick: the row is frozen as seen.
               cap_row_d = bus.curBlock;
               state_d   = S_CHECK;
            end else if (tick_cnt_q == (period_q - 24'd1)) begin
               tick_cnt_d = 24'd0;
               tick_d     = 1'b1;
            end else begin
               tick_cnt_d = tick_cnt_q + 24'd1;
            end
         end

         S_CHECK: begin
            if (overlap == 8'd0) begin
               state_d = S_LOSE;
            end else begin
               stack_row_d = overlap;
               block_loc_d = overlap;
               period_d    = period_dec;
               if (level_q == LAST_LEVEL) begin
                  state_d = S_WIN;
               end else begin
                  level_d    = level_q + 3'd1;
                  state_d    = S_LOAD;
                  tick_cnt_d = 24'd0;
                  load_d     = 1'b1;
               end
            end
         end

         S_WIN, S_LOSE: begin
            if (start_edge) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign bus.blockLoc  = block_loc_q;
   assign bus.loadBlock = load_q;
   assign bus.shiftTick = tick_q;
   assign bus.level     = level_q;
   assign bus.stackRow  = stack_row_q;
   assign bus.gameOver  = (state_q == S_LOSE);
   assign bus.gameWin   = (state_q == S_WIN);

endmodule

// File: tb/tb_stack_game_ctrl.sv
// Self-checking bench for stack_game_ctrl: directed game scenarios plus
// randomized games, checked against a rule-level game model.
module tb_stack_game_ctrl;

   localparam logic [23:0] T_START = 24'd8;
   localparam logic [23:0] T_STEP  = 24'd2;
   localparam logic [23:0] T_MIN   = 24'd4;
   localparam logic [7:0]  T_INIT  = 8'h38;
   localparam int          T_ROWS  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   stack_game_ctrl_if bus ();

   stack_game_ctrl #(
      .START_PERIOD (T_START),
      .PERIOD_STEP  (T_STEP),
      .MIN_PERIOD   (T_MIN),
      .INIT_BLOCK   (T_INIT),
      .ROWS         (T_ROWS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Game model: rows cleared, locked row, shifter pattern, tick period,
   // outcome (0 playing, 1 won, 2 lost), cycles since last load pulse.
   int         m_level;
   int         m_period;
   int         m_done;
   logic [7:0] m_stack;
   logic [7:0] m_block;
   int         cyc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Apply the game rules to a captured row.
   task automatic model_stop(input logic [7:0] cap);
      logic [7:0] ovl;
      ovl = (m_level == 0) ? cap : (cap & m_stack);
      if (ovl == 8'd0) begin
         m_done = 2;
      end else begin
         m_stack  = ovl;
         m_block  = ovl;
         m_period = (m_period - int'(T_STEP) < int'(T_MIN)) ? int'(T_MIN)
                                                              : m_period - int'(T_STEP);
         if (m_level == T_ROWS - 1) m_done = 1;
         else m_level++;
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_load"},  32'(bus.loadBlock), 32'd0);
      check({tag, "_tick"},  32'(bus.shiftTick), 32'd0);
      check({tag, "_level"}, 32'(bus.level),     32'd0);
      check({tag, "_stack"}, 32'(bus.stackRow),  32'd0);
      check({tag, "_bloc"},  32'(bus.blockLoc),  32'd0);
      check({tag, "_over"},  32'(bus.gameOver),  32'd0);
      check({tag, "_win"},   32'(bus.gameWin),   32'd0);
   endtask

   // Advance n cycles in RUN; a tick is due every m_period cycles after load.
   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         cyc++;
         check("run_tick", 32'(bus.shiftTick), 32'((cyc % m_period) == 0));
         check("run_load", 32'(bus.loadBlock), 32'd0);
      end
   endtask

   // WIN/LOSE: flags held, everything else frozen, no pulses.
   task automatic frozen_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         check("frz_tick",  32'(bus.shiftTick), 32'd0);
         check("frz_load",  32'(bus.loadBlock), 32'd0);
         check("frz_win",   32'(bus.gameWin),   32'(m_done == 1));
         check("frz_over",  32'(bus.gameOver),  32'(m_done == 2));
         check("frz_level", 32'(bus.level),     32'(m_level));
         check("frz_stack", 32'(bus.stackRow),  32'(m_stack));
         check("frz_bloc",  32'(bus.blockLoc),  32'(m_block));
      end
   endtask

   task automatic start_game();
      bus.startBtn = 1'b1;
      step();
      bus.startBtn = 1'b0;
      m_level = 0; m_stack = 8'd0; m_block = T_INIT; m_period = int'(T_START);
      m_done = 0; cyc = 0;
      check("start_load",  32'(bus.loadBlock), 32'd1);
      check("start_bloc",  32'(bus.blockLoc),  32'(T_INIT));
      check("start_level", 32'(bus.level),     32'd0);
      check("start_stack", 32'(bus.stackRow),  32'd0);
   endtask

   // Stop press at the current cycle; optionally keep the button held.
   task automatic do_stop(input logic [7:0] cap, input bit hold);
      bus.curBlock = cap;
      bus.stopBtn  = 1'b1;
      step();
      check("chk_tick", 32'(bus.shiftTick), 32'd0);
      check("chk_load", 32'(bus.loadBlock), 32'd0);
      if (!hold) bus.stopBtn = 1'b0;
      model_stop(cap);
      step();
      check("res_tick",  32'(bus.shiftTick), 32'd0);
      check("res_stack", 32'(bus.stackRow),  32'(m_stack));
      check("res_level", 32'(bus.level),     32'(m_level));
      check("res_bloc",  32'(bus.blockLoc),  32'(m_block));
      check("res_load",  32'(bus.loadBlock), 32'(m_done == 0));
      check("res_win",   32'(bus.gameWin),   32'(m_done == 1));
      check("res_over",  32'(bus.gameOver),  32'(m_done == 2));
      cyc = 0;
   endtask

   task automatic end_game_to_idle();
      bus.startBtn = 1'b1;
      step();
      bus.startBtn = 1'b0;
      check("end_win",  32'(bus.gameWin),   32'd0);
      check("end_over", 32'(bus.gameOver),  32'd0);
      check("end_load", 32'(bus.loadBlock), 32'd0);
      step();
   endtask

   initial begin
      logic [7:0] cap;
      int         sh;
      int         guard;

      bus.startBtn = 1'b0;
      bus.stopBtn  = 1'b0;
      bus.curBlock = 8'd0;
      m_level = 0; m_stack = 8'd0; m_block = 8'd0; m_period = int'(T_START);
      m_done = 0; cyc = 0;

      // Reset state
      repeat (3) step();
      check_idle_zero("rst");
      rst = 1'b0;
      step();

      // Stop presses in IDLE do nothing
      for (int i = 0; i < 3; i++) begin
         bus.stopBtn = 1'b1;
         step();
         bus.stopBtn = 1'b0;
         step();
         check_idle_zero("idle_stop");
      end

      // Start with a stop edge landing in the LOAD cycle (ignored)
      start_game();
      bus.stopBtn = 1'b1;
      run_cycles(1);
      bus.stopBtn = 1'b0;
      run_cycles(23);
      check("load_stop_ignored", 32'(bus.level), 32'd0);

      // Stop held for 20 cycles counts once: level 0 -> 1, period 8 -> 6
      do_stop(8'h38, 1'b1);
      run_cycles(18);
      bus.stopBtn = 1'b0;
      check("hold_level", 32'(bus.level), 32'd1);

      // Start edge during RUN is ignored
      bus.startBtn = 1'b1;
      run_cycles(1);
      bus.startBtn = 1'b0;
      run_cycles($urandom_range(2, 10));

      // Trim 0x1C against 0x38 -> 0x18, period 6 -> 4
      do_stop(8'h1C, 1'b0);
      check("trim_stack", 32'(bus.stackRow), 32'h18);

      // Stop coinciding with the last count of the period; period floors at 4
      run_cycles(m_period - 1);
      do_stop(8'h18, 1'b0);
      check("floor_period", 32'(m_period), 32'(T_MIN));
      run_cycles(4);
      check("pre_rst_tick", 32'(bus.shiftTick), 32'd1);

      // Asynchronous reset mid-RUN at level 3
      rst = 1'b1;
      #1;
      check("async_tick", 32'(bus.shiftTick), 32'd0);
      check("async_load", 32'(bus.loadBlock), 32'd0);
      step();
      check_idle_zero("mid_rst");
      rst = 1'b0;
      step();
      for (int i = 0; i < 2; i++) begin
         bus.stopBtn = 1'b1;
         step();
         bus.stopBtn = 1'b0;
         step();
         check_idle_zero("rst_idle_stop");
      end

      // Loss: 0x07 does not overlap 0x38
      start_game();
      run_cycles($urandom_range(1, 12));
      do_stop(8'h38, 1'b0);
      run_cycles($urandom_range(1, 12));
      do_stop(8'h07, 1'b0);
      check("lose_stack", 32'(bus.stackRow), 32'h38);
      bus.stopBtn = 1'b1;
      frozen_cycles(1);
      bus.stopBtn = 1'b0;
      frozen_cycles(8);
      end_game_to_idle();
      start_game();

      // Win: four aligned stops
      for (int i = 0; i < T_ROWS; i++) begin
         run_cycles($urandom_range(1, 12));
         do_stop(8'h38, 1'b0);
      end
      check("win_flag", 32'(m_done), 32'd1);
      frozen_cycles(20);
      end_game_to_idle();

      // Randomized games
      for (int g = 0; g < 6; g++) begin
         start_game();
         guard = 0;
         while (m_done == 0 && guard < T_ROWS) begin
            run_cycles($urandom_range(1, 12));
            sh = $urandom_range(0, 2);
            case ($urandom_range(0, 3))
               0:       cap = 8'($urandom);
               1:       cap = m_block << sh;
               default: cap = m_block >> sh;
            endcase
            do_stop(cap, 1'b0);
            guard++;
         end
         frozen_cycles(5);
         end_game_to_idle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
